// File: rtl/scan_pattern_engine_if.sv
// Pattern beat stream: one load/expect/mask bit per scan chain per beat.
interface scan_pattern_engine_if #(
  parameter int unsigned NCHAINS = 2
);
  logic               beat_valid;
  logic               beat_ready;
  logic [NCHAINS-1:0] beat_load;
  logic [NCHAINS-1:0] beat_exp;
  logic [NCHAINS-1:0] beat_mask;

  modport master (
    output beat_valid,
    output beat_load,
    output beat_exp,
    output beat_mask,
    input  beat_ready
  );

  modport slave (
    input  beat_valid,
    input  beat_load,
    input  beat_exp,
    input  beat_mask,
    output beat_ready
  );
endinterface

// File: rtl/scan_pattern_engine.sv
// On-chip scan applicator: overlapped load/unload of NCHAINS chains, single or LOC capture,
// masked miscompare counting with saturation and first-failing-pattern capture.
module scan_pattern_engine #(
  parameter int unsigned NCHAINS   = 2,
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned PAT_W     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_mode_loc,
  input  logic [PAT_W-1:0]     i_num_patterns,
  scan_pattern_engine_if.slave io_beat,
  output logic [NCHAINS-1:0]   o_test_si,
  input  logic [NCHAINS-1:0]   i_test_so,
  output logic                 o_test_se,
  output logic                 o_dut_clk_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_fail_count,
  output logic [PAT_W-1:0]     o_first_fail,
  output logic                 o_fail_seen
);

  localparam int unsigned SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned POP_W = $clog2(NCHAINS + 1);
  localparam logic [SC_W-1:0] LastBeat = SC_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StShift, StSeFall, StCap1, StCap2, StSeRise, StDone
  } state_e;

  state_e             r_state, w_state_nxt;
  logic               r_mode;
  logic [PAT_W-1:0]   r_num;
  logic [PAT_W-1:0]   r_phase;
  logic [SC_W-1:0]    r_shift_cnt;
  logic [CNT_W-1:0]   r_fail_count;
  logic [PAT_W-1:0]   r_first_fail;
  logic               r_fail_seen;

  logic               w_accept;
  logic               w_last_beat;
  logic               w_final_phase;
  logic               w_cmp;
  logic [NCHAINS-1:0] w_miss;
  logic [POP_W-1:0]   w_pop;
  logic [CNT_W:0]     w_sum;

  assign w_accept      = (r_state == StShift) && io_beat.beat_valid;
  assign w_final_phase = (r_phase == r_num);
  assign w_last_beat   = w_accept && (r_shift_cnt == LastBeat);
  // Phase 0 only loads; there is no previous response to unload yet.
  assign w_cmp         = w_accept && (r_phase != '0);
  assign w_miss        = io_beat.beat_mask & (i_test_so ^ io_beat.beat_exp) & {NCHAINS{w_cmp}};

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NCHAINS; c++) begin
      w_pop = w_pop + POP_W'(w_miss[c]);
    end
  end

  assign w_sum = {1'b0, r_fail_count} + (CNT_W + 1)'(w_pop);

  always_comb begin
    w_state_nxt         = r_state;
    o_test_se           = 1'b0;
    o_dut_clk_en        = 1'b0;
    o_test_si           = '0;
    io_beat.beat_ready  = 1'b0;
    o_busy              = 1'b1;
    o_done              = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = (i_num_patterns == '0) ? StDone : StShift;
      end
      StShift: begin
        o_test_se          = 1'b1;
        io_beat.beat_ready = 1'b1;
        o_dut_clk_en       = io_beat.beat_valid;
        if (w_accept && !w_final_phase) o_test_si = io_beat.beat_load;
        if (w_last_beat) w_state_nxt = w_final_phase ? StDone : StSeFall;
      end
      StSeFall: w_state_nxt = StCap1;
      StCap1: begin
        o_dut_clk_en = 1'b1;
        w_state_nxt  = r_mode ? StCap2 : StSeRise;
      end
      StCap2: begin
        o_dut_clk_en = 1'b1;
        w_state_nxt  = StSeRise;
      end
      StSeRise: begin
        o_test_se   = 1'b1;
        w_state_nxt = StShift;
      end
      StDone: begin
        o_busy      = 1'b0;
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_mode       <= 1'b0;
      r_num        <= '0;
      r_phase      <= '0;
      r_shift_cnt  <= '0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && i_start) begin
        r_mode       <= i_mode_loc;
        r_num        <= i_num_patterns;
        r_phase      <= '0;
        r_shift_cnt  <= '0;
        r_fail_count <= '0;
        r_first_fail <= '0;
        r_fail_seen  <= 1'b0;
      end
      if (w_last_beat) begin
        r_shift_cnt <= '0;
      end else if (w_accept) begin
        r_shift_cnt <= r_shift_cnt + 1'b1;
      end
      if (r_state == StSeRise) begin
        r_phase     <= r_phase + 1'b1;
        r_shift_cnt <= '0;
      end
      if (w_cmp) begin
        r_fail_count <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        if ((|w_miss) && !r_fail_seen) begin
          r_fail_seen  <= 1'b1;
          r_first_fail <= r_phase - 1'b1;
        end
      end
    end
  end

  assign o_fail_count = r_fail_count;
  assign o_first_fail = r_first_fail;
  assign o_fail_seen  = r_fail_seen;

endmodule
